// File: rtl/game_pkg.sv
// Shared game types: player-lives state, restart keycodes, default widths.
// Keycodes are shared with the explosion sequencer so both release together.
package game_pkg;

    typedef enum logic [2:0] {
        ALIVE,
        INVULN,
        REQ,
        WAIT_GO,
        DEAD
    } lives_state_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_W     = 8'h1A;

    localparam int LIVES_W_DEF = 2;

    function automatic logic is_restart_key(input logic [7:0] k);
        return (k == KEY_ENTER) || (k == KEY_SPACE) || (k == KEY_W);
    endfunction

endpackage

// File: rtl/player_lives_ctrl_invuln_timer.sv
// Loadable invulnerability down-counter with a zero flag and a blink tap.
// blink_next is the ship visibility for the count the next cycle will hold.
module invuln_timer
    import game_pkg::*;
#(
    parameter int TICKS = 32,
    parameter int W     = $clog2(TICKS)
) (
    input  logic clkdiv2,
    input  logic Reset,
    input  logic load,
    input  logic run,
    output logic done,
    output logic blink_next
);

    localparam int TAP = (W > 2) ? 2 : W - 1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_d;

    // next count: load wins, otherwise count down to zero while running
    always_comb begin
        cnt_d = cnt;
        if (load) begin
            cnt_d = W'(TICKS - 1);
        end else if (run && (cnt != '0)) begin
            cnt_d = cnt - W'(1);
        end
    end

    // count register
    always_ff @(posedge clkdiv2 or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_d;
        end
    end

    assign done       = (cnt == '0);
    assign blink_next = ~cnt_d[TAP];

endmodule

// File: rtl/player_lives_ctrl.sv
// Player lives, invulnerability window and explode handshake to the sequencer.
// Optional macro PLAYER_EXTRA_LIFE_EN adds the extra_life input.
module player_lives_ctrl
    import game_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 3,
    parameter int LIVES_W      = LIVES_W_DEF,
    parameter int INVULN_TICKS = 32
) (
    input  logic               clkdiv2,
    input  logic               Reset,
    input  logic               hit,
    input  logic               explosion0,
    input  logic               game_over,
    input  logic [15:0]        keycode,
`ifdef PLAYER_EXTRA_LIFE_EN
    input  logic               extra_life,
`endif
    output logic               explode,
    output logic [LIVES_W-1:0] lives,
    output logic               invuln,
    output logic               ship_visible
);

    lives_state_t       state;
    lives_state_t       state_d;
    logic [LIVES_W-1:0] lives_d;
    logic               load;
    logic               run;
    logic               done;
    logic               blink_next;
    logic               bonus;
    logic               unused_key;

`ifdef PLAYER_EXTRA_LIFE_EN
    assign bonus = extra_life;
`else
    assign bonus = 1'b0;
`endif

    assign unused_key = ^keycode[15:8];
    assign run        = (state == INVULN);

    invuln_timer #(
        .TICKS(INVULN_TICKS)
    ) u_timer (
        .clkdiv2   (clkdiv2),
        .Reset     (Reset),
        .load      (load),
        .run       (run),
        .done      (done),
        .blink_next(blink_next)
    );

    // saturating lives increment for the extra-life bonus
    function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] l);
        return (l < LIVES_W'(MAX_LIVES)) ? l + LIVES_W'(1) : l;
    endfunction

    // next state, next lives and timer load
    always_comb begin
        state_d = state;
        lives_d = lives;
        load    = 1'b0;
        unique case (state)
            ALIVE: begin
                if (hit) begin
                    if ((lives > LIVES_W'(1)) || bonus) begin
                        load    = 1'b1;
                        state_d = INVULN;
                        if (!bonus) lives_d = lives - LIVES_W'(1);
                    end else begin
                        lives_d = '0;
                        state_d = REQ;
                    end
                end else if (bonus) begin
                    lives_d = sat_inc(lives);
                end
            end
            INVULN: begin
                if (bonus) lives_d = sat_inc(lives);
                if (done) state_d = ALIVE;
            end
            REQ: begin
                if (explosion0) state_d = WAIT_GO;
            end
            WAIT_GO: begin
                if (game_over) state_d = DEAD;
            end
            DEAD: begin
                if (is_restart_key(keycode[7:0])) begin
                    state_d = ALIVE;
                    lives_d = LIVES_W'(START_LIVES);
                end
            end
            default: state_d = ALIVE;
        endcase
    end

    // state, lives and registered outputs
    always_ff @(posedge clkdiv2 or posedge Reset) begin
        if (Reset) begin
            state        <= ALIVE;
            lives        <= LIVES_W'(START_LIVES);
            explode      <= 1'b0;
            invuln       <= 1'b0;
            ship_visible <= 1'b1;
        end else begin
            state   <= state_d;
            lives   <= lives_d;
            explode <= (state_d == REQ);
            invuln  <= (state_d == INVULN);
            unique case (state_d)
                INVULN:        ship_visible <= blink_next;
                WAIT_GO, DEAD: ship_visible <= 1'b0;
                default:       ship_visible <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_player_lives_ctrl.sv
// Randomized self-checking bench for player_lives_ctrl.
// Reference model tracks phase, lives and elapsed window cycles directly.
module tb_player_lives_ctrl;

    localparam int TICKS = 32;
    localparam int START = 3;
    localparam int MAXL  = 3;

    logic        clkdiv2 = 1'b0;
    logic        Reset;
    logic        hit;
    logic        explosion0;
    logic        game_over;
    logic [15:0] keycode;
    logic        explode;
    logic [1:0]  lives;
    logic        invuln;
    logic        ship_visible;
    logic        xl;
`ifdef PLAYER_EXTRA_LIFE_EN
    logic        extra_life;
    assign extra_life = xl;
`endif

    always #5 clkdiv2 = ~clkdiv2;

    player_lives_ctrl dut (
        .clkdiv2     (clkdiv2),
        .Reset       (Reset),
        .hit         (hit),
        .explosion0  (explosion0),
        .game_over   (game_over),
        .keycode     (keycode),
`ifdef PLAYER_EXTRA_LIFE_EN
        .extra_life  (extra_life),
`endif
        .explode     (explode),
        .lives       (lives),
        .invuln      (invuln),
        .ship_visible(ship_visible)
    );

    int checks   = 0;
    int failures = 0;

    // model: phase 0 alive, 1 shielded, 2 requesting, 3 awaiting, 4 dead
    int m_phase;
    int m_lives;
    int m_el;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_lives = START;
        m_el    = 0;
    endtask

    function automatic int bump(input int l);
        return (l < MAXL) ? l + 1 : l;
    endfunction

    function automatic bit restart_key(input logic [7:0] k);
        return (k == 8'h28) || (k == 8'h2C) || (k == 8'h1A);
    endfunction

    task automatic model_step();
        bit x;
        x = 1'b0;
`ifdef PLAYER_EXTRA_LIFE_EN
        x = xl;
`endif
        case (m_phase)
            0: begin
                if (hit) begin
                    if (m_lives > 1 || x) begin
                        if (!x) m_lives = m_lives - 1;
                        m_phase = 1;
                        m_el    = 0;
                    end else begin
                        m_lives = 0;
                        m_phase = 2;
                    end
                end else if (x) begin
                    m_lives = bump(m_lives);
                end
            end
            1: begin
                if (x) m_lives = bump(m_lives);
                if (m_el == TICKS - 1) m_phase = 0;
                else m_el++;
            end
            2: if (explosion0) m_phase = 3;
            3: if (game_over) m_phase = 4;
            default: begin
                if (restart_key(keycode[7:0])) begin
                    m_phase = 0;
                    m_lives = START;
                end
            end
        endcase
    endtask

    task automatic compare();
        int rem;
        chk("explode", explode, m_phase == 2);
        chk("lives", lives, m_lives);
        chk("invuln", invuln, m_phase == 1);
        rem = TICKS - 1 - m_el;
        if (m_phase == 1) chk("blink", ship_visible, ((rem / 4) % 2) == 0);
        else if (m_phase >= 3) chk("ship_hidden", ship_visible, 0);
        else if (m_phase == 0) chk("ship_shown", ship_visible, 1);
    endtask

    task automatic step();
        @(posedge clkdiv2);
        model_step();
        #1;
        compare();
    endtask

    task automatic drive(input bit h, input bit e0, input bit go,
                         input logic [15:0] key, input bit x);
        hit        = h;
        explosion0 = e0;
        game_over  = go;
        keycode    = key;
        xl         = x;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 16'h0000, 0);
    endtask

    task automatic async_reset_check();
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        chk("arst_explode", explode, 0);
        chk("arst_lives", lives, START);
        chk("arst_invuln", invuln, 0);
        chk("arst_ship", ship_visible, 1);
        @(posedge clkdiv2);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        logic [15:0] keys [5];
        int kr;
        keys[0] = 16'h0028;
        keys[1] = 16'h002C;
        keys[2] = 16'h001A;
        keys[3] = 16'h0004;
        keys[4] = 16'hA52C;

        Reset      = 1'b1;
        hit        = 1'b0;
        explosion0 = 1'b0;
        game_over  = 1'b0;
        keycode    = 16'h0000;
        xl         = 1'b0;
        model_reset();
        #12;
        compare();
        @(posedge clkdiv2);
        #1;
        Reset = 1'b0;

        // first hit at cycle 5, hits inside the window ignored
        idle(4);
        drive(1, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 40; i++)
            drive((i < 30) ? 1'($urandom % 2) : 1'b0, 0, 0, 16'h0000, 0);

        // two more hits, then explode held 10 cycles until acknowledged
        drive(1, 0, 0, 16'h0000, 0);
        idle(39);
        drive(1, 0, 0, 16'h0000, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, i % 2, 16'h002C, 0);
        drive(0, 1, 0, 16'h0000, 0);
        idle(3);
        drive(0, 0, 1, 16'h0000, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 16'h0004, 0);
        drive(0, 0, 0, 16'h002C, 0);
        idle(2);

        // level hit: expiry-cycle hit ignored, then decrements, then fatal
        for (int i = 0; i < 80; i++) drive(1, 0, 0, 16'h0000, 0);
        hit = 1'b0;
        chk("in_req", explode, 1);
        async_reset_check();
        idle(3);

`ifdef PLAYER_EXTRA_LIFE_EN
        drive(0, 0, 0, 16'h0000, 1);
        drive(1, 0, 0, 16'h0000, 0);
        idle(35);
        drive(1, 0, 0, 16'h0000, 0);
        idle(35);
        drive(1, 0, 0, 16'h0000, 1);
        idle(35);
`endif

        // randomized traffic
        for (int i = 0; i < 5000; i++) begin
            kr = $urandom_range(0, 4);
            drive(($urandom % 16) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                  (($urandom % 4) == 0) ? keys[kr] : 16'($urandom),
                  ($urandom % 20) == 0);
            if (($urandom % 700) == 0) async_reset_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
